// File: rtl/bitonic_sort8_seq_pkg.sv
// Shared constants and types for the sequential 8-word bitonic sorter.
// Stage table (k,j), FSM encoding, and the pair-index helper.
package bitonic_pkg;

   localparam int N    = 8;
   localparam int NSTG = 6;

   localparam logic [3:0] STG_K [NSTG] =
      '{4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8};
   localparam logic [2:0] STG_J [NSTG] =
      '{3'd1, 3'd2, 3'd1, 3'd4, 3'd2, 3'd1};

   typedef logic [1:0] state_t;
   localparam state_t LOAD  = 2'd0;
   localparam state_t SORT  = 2'd1;
   localparam state_t DRAIN = 2'd2;

   // p-th index i with (i & j)==0: insert a zero
   // bit at position log2(j) of p.
   function automatic logic [2:0] pair_lo(
      input logic [1:0] p,
      input logic [2:0] j
   );
      logic [2:0] m;
      logic [2:0] pp;
      m  = j - 3'd1;
      pp = {1'b0, p};
      return (pp & m) | ((pp & ~m) << 1);
   endfunction

endpackage

// File: rtl/bitonic_sort8_seq_if.sv
// Input/output stream bundle of the bitonic sorter.
// master = traffic source/sink, slave = sorter.
interface bitonic_sort8_seq_if #(
   parameter int DW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data,
      input  out_last, busy
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data,
      output out_last, busy
   );
endinterface

// File: rtl/bitonic_sort8_seq_cex.sv
// Compare-exchange cell: d=0 puts the smaller word on lo.
// Ports: a, b in; d direction; lo, hi out.
module bitonic_cex #(
   parameter int DW = 8
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          d,
   output logic [DW-1:0] lo,
   output logic [DW-1:0] hi
);
   logic swap;

   assign swap = d ^ (a > b);
   assign lo   = swap ? b : a;
   assign hi   = swap ? a : b;
endmodule

// File: rtl/bitonic_sort8_seq.sv
// Sequential 8-word bitonic sorter: load, 6 sort stages, drain.
// Ports: clk, rst_n (async low), s = stream slave bundle.
module bitonic_sort8_seq
   import bitonic_pkg::*;
#(
   parameter int DW  = 8,
   parameter bit DIR = 1'b0
) (
   input logic clk,
   input logic rst_n,
   bitonic_sort8_seq_if.slave s
);
   state_t        state;
   logic [2:0]    cnt;
   logic [2:0]    stg;
   logic [DW-1:0] bank [N];

   logic [2:0]    j;
   logic [3:0]    k;
   logic [2:0]    ia [4];
   logic [2:0]    ib [4];
   logic          cd [4];
   logic [DW-1:0] ca [4];
   logic [DW-1:0] cb [4];
   logic [DW-1:0] lo [4];
   logic [DW-1:0] hi [4];

   assign s.in_ready  = (state == LOAD);
   assign s.out_valid = (state == DRAIN);
   assign s.out_data  = bank[cnt];
   assign s.out_last  = (state == DRAIN) && (cnt == 3'd7);
   assign s.busy      = (state != LOAD);

   // Pair selection for the current stage.
   always_comb begin
      j = STG_J[stg];
      k = STG_K[stg];
      for (int p = 0; p < 4; p++) begin
         ia[p] = pair_lo(2'(p), j);
         ib[p] = ia[p] + j;
         cd[p] = DIR ^ (|({1'b0, ia[p]} & k));
         ca[p] = bank[ia[p]];
         cb[p] = bank[ib[p]];
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_cex
      bitonic_cex #(.DW(DW)) u_cex (
         .a  (ca[g]),
         .b  (cb[g]),
         .d  (cd[g]),
         .lo (lo[g]),
         .hi (hi[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
         cnt   <= '0;
         stg   <= '0;
         for (int i = 0; i < N; i++)
            bank[i] <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (s.in_valid) begin
                  bank[cnt] <= s.in_data;
                  cnt       <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     stg   <= '0;
                     state <= SORT;
                  end
               end
            end
            SORT: begin
               for (int p = 0; p < 4; p++) begin
                  bank[ia[p]] <= lo[p];
                  bank[ib[p]] <= hi[p];
               end
               if (stg == 3'd5) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end else begin
                  stg <= stg + 3'd1;
               end
            end
            DRAIN: begin
               if (s.out_ready) begin
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7)
                     state <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_bitonic_sort8_seq.sv
// Directed and random bench for bitonic_sort8_seq.
// Runs an ascending and a descending instance in lockstep.
module tb_bitonic_sort8_seq;
   typedef logic [7:0] w8_t;
   typedef struct {
      w8_t din [8];
      w8_t asc [8];
      w8_t dsc [8];
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid;
   logic out_ready;
   w8_t  in_data;

   int n_chk  = 0;
   int n_fail = 0;

   bitonic_sort8_seq_if #(.DW(8)) if0 ();
   bitonic_sort8_seq_if #(.DW(8)) if1 ();

   assign if0.in_valid  = in_valid;
   assign if0.in_data   = in_data;
   assign if0.out_ready = out_ready;
   assign if1.in_valid  = in_valid;
   assign if1.in_data   = in_data;
   assign if1.out_ready = out_ready;

   bitonic_sort8_seq #(.DW(8), .DIR(1'b0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (if0)
   );

   bitonic_sort8_seq #(.DW(8), .DIR(1'b1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (if1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic load(input w8_t v [8], input bit rnd);
      int  i;
      int  g;
      bit  hs;
      i = 0;
      g = 0;
      while (i < 8 && g < 200) begin
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = v[i];
         chk("load_in_ready", 32'(if0.in_ready), 1);
         chk("load_busy", 32'(if0.busy), 0);
         chk("load_out_valid", 32'(if0.out_valid), 0);
         hs = in_valid && if0.in_ready;
         @(posedge clk);
         #1;
         if (hs) i++;
         g++;
      end
      if (g >= 200) chk("load_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input w8_t ea [8],
                        input w8_t ed [8],
                        input int mode);
      int         n;
      int         j;
      int         ph;
      int         g;
      bit         stl;
      w8_t        pd;
      logic       pl;
      logic [3:0] pat;
      pat = 4'b1001;
      // garbage on in_data must be ignored while busy
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      out_ready = 1'b0;
      n = 0;
      while (!if0.out_valid && n < 20) begin
         chk("sort_busy", 32'(if0.busy), 1);
         chk("sort_in_ready", 32'(if0.in_ready), 0);
         @(posedge clk);
         #1;
         n++;
         in_data = 8'($urandom);
      end
      chk("latency_cycles", 32'(n + 1), 7);
      j   = 0;
      ph  = 0;
      g   = 0;
      stl = 1'b0;
      pd  = '0;
      pl  = 1'b0;
      while (j < 8 && g < 200) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[ph % 4];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         ph++;
         chk("out_valid0", 32'(if0.out_valid), 1);
         chk("out_valid1", 32'(if1.out_valid), 1);
         if (stl) begin
            chk("stall_data", 32'(if0.out_data), 32'(pd));
            chk("stall_last", 32'(if0.out_last), 32'(pl));
         end
         chk("data_asc", 32'(if0.out_data), 32'(ea[j]));
         chk("data_dsc", 32'(if1.out_data), 32'(ed[j]));
         chk("last_asc", 32'(if0.out_last), 32'(j == 7));
         chk("last_dsc", 32'(if1.out_last), 32'(j == 7));
         chk("drain_in_ready", 32'(if0.in_ready), 0);
         chk("drain_busy", 32'(if0.busy), 1);
         stl = !out_ready;
         pd  = if0.out_data;
         pl  = if0.out_last;
         if (out_ready) j++;
         @(posedge clk);
         #1;
         in_data = 8'($urandom);
         g++;
      end
      if (g >= 200) chk("drain_timeout", 0, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("post_busy", 32'(if0.busy), 0);
      chk("post_in_ready", 32'(if0.in_ready), 1);
      chk("post_out_valid", 32'(if1.out_valid), 0);
   endtask

   function automatic void ref_sort(input w8_t v [8],
                                    output w8_t a [8],
                                    output w8_t d [8]);
      w8_t t;
      a = v;
      for (int x = 1; x < 8; x++)
         for (int y = x; y > 0 && a[y-1] > a[y]; y--) begin
            t      = a[y];
            a[y]   = a[y-1];
            a[y-1] = t;
         end
      for (int x = 0; x < 8; x++)
         d[x] = a[7-x];
   endfunction

   vec_t tbl [5];
   w8_t  rv [8];
   w8_t  ra [8];
   w8_t  rd [8];

   initial begin
      tbl[0].din = '{8'd7, 8'd6, 8'd5, 8'd4,
                     8'd3, 8'd2, 8'd1, 8'd0};
      tbl[0].asc = '{8'd0, 8'd1, 8'd2, 8'd3,
                     8'd4, 8'd5, 8'd6, 8'd7};
      tbl[0].dsc = '{8'd7, 8'd6, 8'd5, 8'd4,
                     8'd3, 8'd2, 8'd1, 8'd0};
      tbl[1].din = '{8'd3, 8'd1, 8'd4, 8'd1,
                     8'd5, 8'd9, 8'd2, 8'd6};
      tbl[1].asc = '{8'd1, 8'd1, 8'd2, 8'd3,
                     8'd4, 8'd5, 8'd6, 8'd9};
      tbl[1].dsc = '{8'd9, 8'd6, 8'd5, 8'd4,
                     8'd3, 8'd2, 8'd1, 8'd1};
      tbl[2].din = '{default: 8'hAA};
      tbl[2].asc = '{default: 8'hAA};
      tbl[2].dsc = '{default: 8'hAA};
      tbl[3].din = '{8'hFF, 8'h00, 8'hFF, 8'h00,
                     8'hFF, 8'h00, 8'hFF, 8'h00};
      tbl[3].asc = '{8'h00, 8'h00, 8'h00, 8'h00,
                     8'hFF, 8'hFF, 8'hFF, 8'hFF};
      tbl[3].dsc = '{8'hFF, 8'hFF, 8'hFF, 8'hFF,
                     8'h00, 8'h00, 8'h00, 8'h00};
      tbl[4].din = '{8'h10, 8'h80, 8'h20, 8'h70,
                     8'h30, 8'h60, 8'h40, 8'h50};
      tbl[4].asc = '{8'h10, 8'h20, 8'h30, 8'h40,
                     8'h50, 8'h60, 8'h70, 8'h80};
      tbl[4].dsc = '{8'h80, 8'h70, 8'h60, 8'h50,
                     8'h40, 8'h30, 8'h20, 8'h10};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      #1;
      chk("rst_in_ready", 32'(if0.in_ready), 1);
      chk("rst_out_valid", 32'(if0.out_valid), 0);
      chk("rst_out_last", 32'(if1.out_last), 0);
      chk("rst_busy", 32'(if0.busy), 0);
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int t = 0; t < 5; t++) begin
         load(tbl[t].din, 1'b0);
         drain(tbl[t].asc, tbl[t].dsc, 0);
      end

      load(tbl[1].din, 1'b0);
      drain(tbl[1].asc, tbl[1].dsc, 1);

      // abort a half-loaded frame with reset
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'hE0 + i);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(if0.in_ready), 1);
      chk("mid_rst_busy", 32'(if0.busy), 0);
      chk("mid_rst_out_valid", 32'(if1.out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rv = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      ref_sort(rv, ra, rd);
      load(rv, 1'b0);
      drain(ra, rd, 0);

      for (int f = 0; f < 100; f++) begin
         for (int i = 0; i < 8; i++)
            rv[i] = 8'($urandom);
         if (f % 10 == 3) rv[2] = rv[5];
         ref_sort(rv, ra, rd);
         load(rv, 1'b1);
         drain(ra, rd, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
